alu_muldiv: RTL

Parametrised next-generation execute-stage ALU for the MIPS core. It keeps the single-cycle combinational ALU datapath: logic, add/sub, compares, shifts, LUI. It adds signed/unsigned compare, an overflow flag, and an iterative multiply/divide unit with architectural HI/LO registers driven by a start/busy/done handshake. The pipeline controller stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/alu_muldiv_if.sv | 30 +++
 rtl/alu_muldiv.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_if.sv
// Execute-stage ALU bus: operands, op selects, combinational result/flags,
// and the mul/div handshake with the architectural HI/LO registers.
interface alu_muldiv_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       ALUCtrl;
  logic [SHW-1:0]   shift_amount;
  logic             md_start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, ALUCtrl, shift_amount, md_start, md_op,
    input  result, zero, overflow, busy, done, hi, lo
  );

  modport slave (
    input  a, b, ALUCtrl, shift_amount, md_start, md_op,
    output result, zero, overflow, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: single-cycle combinational datapath plus an iterative
// radix-2 multiply/divide unit writing HI/LO after WIDTH+1 cycles.
module alu_muldiv #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic        clk,
  input  logic        rst,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, FIX = 2'b10} state_t;

  // Two's-complement negate of a WIDTH-bit value.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude of a value, treated as signed only when sgn is set.
  function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) return neg_w(v);
    else return v;
  endfunction

  state_t             state_r, state_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;      // product, or {remainder, quotient/dividend}
  logic [WIDTH-1:0]   mcand_r;    // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   a_orig_r;   // raw dividend for the divide-by-zero result
  logic               div_r, neg_q_r, neg_rem_r, dz_r;
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  logic               load_s, fix_s, mthi_s, mtlo_s;
  logic               neg_a_s, neg_b_s;
  logic [SHW-1:0]     sh_s;
  logic [WIDTH-1:0]   sum_s, dif_s, result_s;
  logic               ovf_s;
  logic [WIDTH:0]     mul_up_s, rem_sh_s, diff_s;
  logic [2*WIDTH-1:0] step_s, prod_s;
  logic [WIDTH-1:0]   hi_fix_s, lo_fix_s;

  assign sh_s    = bus.shift_amount;
  assign neg_a_s = ~bus.md_op[0] & bus.a[WIDTH-1];
  assign neg_b_s = ~bus.md_op[0] & bus.b[WIDTH-1];

  // Combinational ALU result and signed-overflow flag; live regardless of busy.
  always_comb begin
    sum_s    = bus.a + bus.b;
    dif_s    = bus.a - bus.b;
    result_s = {WIDTH{1'b0}};
    ovf_s    = 1'b0;
    case (bus.ALUCtrl)
      4'b0000: result_s = bus.a & bus.b;
      4'b0001: result_s = bus.a | bus.b;
      4'b0010: begin
        result_s = sum_s;
        ovf_s    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b0011: result_s = bus.a ^ bus.b;
      4'b0110: begin
        result_s = dif_s;
        ovf_s    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b1100: result_s = ~(bus.a | bus.b);
      4'b0111: result_s = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      4'b0100: result_s = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      4'b1000: result_s = bus.b << sh_s;
      4'b1001: result_s = bus.b >> sh_s;
      4'b1010: result_s = $signed(bus.b) >>> sh_s;
      4'b1011: result_s = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  assign bus.result   = result_s;
  assign bus.zero     = (result_s == {WIDTH{1'b0}});
  assign bus.overflow = ovf_s;

  // Mul/div FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next state and control strobes; starts and moves only act from IDLE.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    fix_s   = 1'b0;
    mthi_s  = 1'b0;
    mtlo_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.md_start && (bus.md_op[2] == 1'b0)) begin
          state_s = RUN;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
          mthi_s  = bus.md_start && (bus.md_op == 3'b100);
          mtlo_s  = bus.md_start && (bus.md_op == 3'b101);
        end
      end
      RUN: begin
        if (cnt_r == LAST) state_s = FIX;
        else               state_s = RUN;
      end
      FIX: begin
        state_s = IDLE;
        fix_s   = 1'b1;
      end
      default: state_s = IDLE;
    endcase
  end

  // One radix-2 step: shift-add multiply or restoring shift-subtract divide.
  always_comb begin
    if (acc_r[0]) mul_up_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    else          mul_up_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    rem_sh_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    diff_s   = rem_sh_s - {1'b0, mcand_r};
    if (div_r) begin
      if (diff_s[WIDTH]) step_s = {rem_sh_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      else               step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
    end else begin
      step_s = {mul_up_s, acc_r[WIDTH-1:1]};
    end
  end

  // Sign correction and special cases for the final HI/LO write.
  always_comb begin
    if (neg_q_r) prod_s = ~acc_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
    else         prod_s = acc_r;
    if (!div_r) begin
      hi_fix_s = prod_s[2*WIDTH-1:WIDTH];
      lo_fix_s = prod_s[WIDTH-1:0];
    end else if (dz_r) begin
      hi_fix_s = a_orig_r;
      lo_fix_s = {WIDTH{1'b1}};
    end else begin
      if (neg_q_r)   lo_fix_s = neg_w(acc_r[WIDTH-1:0]);
      else           lo_fix_s = acc_r[WIDTH-1:0];
      if (neg_rem_r) hi_fix_s = neg_w(acc_r[2*WIDTH-1:WIDTH]);
      else           hi_fix_s = acc_r[2*WIDTH-1:WIDTH];
    end
  end

  // Operand latch, iteration, HI/LO writes and the busy/done handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      a_orig_r  <= {WIDTH{1'b0}};
      div_r     <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      done_r <= fix_s;
      if (load_s) begin
        cnt_r     <= {CW{1'b0}};
        acc_r     <= {{WIDTH{1'b0}}, abs_w(bus.a, ~bus.md_op[0])};
        mcand_r   <= abs_w(bus.b, ~bus.md_op[0]);
        a_orig_r  <= bus.a;
        div_r     <= bus.md_op[1];
        neg_q_r   <= neg_a_s ^ neg_b_s;
        neg_rem_r <= neg_a_s;
        dz_r      <= (bus.b == {WIDTH{1'b0}});
        busy_r    <= 1'b1;
      end else if (state_r == RUN) begin
        acc_r <= step_s;
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else if (fix_s) begin
        hi_r   <= hi_fix_s;
        lo_r   <= lo_fix_s;
        busy_r <= 1'b0;
      end else if (mthi_s) begin
        hi_r <= bus.a;
      end else if (mtlo_s) begin
        lo_r <= bus.a;
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule
